z8_extmem_responder: RTL and testbench

// - Target side of the Z8 external memory bus (Port 0 = A15..A8, Port 1 = multiplexed AD7..0, /AS, /DS, R/W).
// - The processor core initiates each cycle. This block decodes it, holds a local RAM window and answers reads and writes.
// - It sits in the SoC beside the core, on the same clock, and serves as the external RAM/ROM model for SoC benches.

---
 rtl/z8_extmem_responder.sv | 159 +++++++++++++++
 tb/tb_z8_extmem_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/z8_extmem_responder.sv
// Target side of the Z8 external memory bus: decodes core-initiated cycles
// against a local RAM window and answers reads (with optional wait states) and writes.
module z8_extmem_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h1000,
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as_n,
  input  logic        ds_n,
  input  logic        rw,
  input  logic [7:0]  addr_hi,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        wait_n,
  output logic        rd_strobe,
  output logic        wr_strobe,
  output logic [15:0] sel_addr
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR    = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] WR      = 3'd4;

  localparam int          DEPTH = 1 << ADDR_BITS;
  localparam logic [16:0] LIMIT = {1'b0, BASE_ADDR} + 17'(DEPTH);

  logic [2:0]           state_q, state_d;
  logic                 as_q, ds_q;
  logic [15:0]          sel_addr_q, sel_addr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           ad_out_q, ad_out_d;
  logic                 ad_oe_q, ad_oe_d;
  logic                 rd_strobe_q, rd_strobe_d;
  logic                 wr_strobe_q, wr_strobe_d;
  logic [7:0]           rdata_q;
  logic [7:0]           mem_q [DEPTH];
  logic                 mem_re, mem_we;
  logic                 as_rise, as_fall, ds_rise, ds_fall;
  logic                 hit;
  logic [ADDR_BITS-1:0] idx;

  assign as_rise = as_n & ~as_q;
  assign as_fall = ~as_n & as_q;
  assign ds_rise = ds_n & ~ds_q;
  assign ds_fall = ~ds_n & ds_q;

  // 17-bit compare so a window ending at 16'hFFFF does not overflow the limit
  assign hit = ({1'b0, sel_addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, sel_addr_q} < LIMIT);
  assign idx = ADDR_BITS'(sel_addr_q - BASE_ADDR);

  always_comb begin
    state_d     = state_q;
    sel_addr_d  = sel_addr_q;
    cnt_d       = cnt_q;
    ad_out_d    = ad_out_q;
    ad_oe_d     = ad_oe_q;
    rd_strobe_d = 1'b0;
    wr_strobe_d = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;

    if (as_rise) sel_addr_d = {addr_hi, ad_in};

    // A new /AS falling edge aborts whatever cycle is in flight
    if (state_q != IDLE && as_fall) begin
      state_d = IDLE;
      ad_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (as_rise) state_d = ADDR;
        ADDR: begin
          if (!as_rise && ds_fall) begin
            if (!hit) begin
              state_d = IDLE;
            end else if (rw) begin
              state_d = RD_WAIT;
              mem_re  = 1'b1;
              cnt_d   = 4'(WAIT_CYCLES);
            end else begin
              state_d = WR;
            end
          end
        end
        RD_WAIT: begin
          if (ds_rise) begin
            state_d = IDLE;
          end else if (cnt_q == 4'd0) begin
            state_d     = RD_DATA;
            ad_oe_d     = 1'b1;
            ad_out_d    = rdata_q;
            rd_strobe_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RD_DATA: begin
          if (ds_rise) begin
            state_d = IDLE;
            ad_oe_d = 1'b0;
          end
        end
        WR: begin
          if (ds_rise) begin
            mem_we      = 1'b1;
            wr_strobe_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          ad_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      as_q        <= 1'b1;
      ds_q        <= 1'b1;
      sel_addr_q  <= 16'h0000;
      cnt_q       <= 4'd0;
      ad_out_q    <= 8'h00;
      ad_oe_q     <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      as_q        <= as_n;
      ds_q        <= ds_n;
      sel_addr_q  <= sel_addr_d;
      cnt_q       <= cnt_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      rd_strobe_q <= rd_strobe_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  // RAM array and its read register keep their contents across reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= ad_in;
    if (mem_re) rdata_q <= mem_q[idx];
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign wait_n    = !(state_q == RD_WAIT && cnt_q != 4'd0);
  assign rd_strobe = rd_strobe_q;
  assign wr_strobe = wr_strobe_q;
  assign sel_addr  = sel_addr_q;

endmodule

// File: tb/tb_z8_extmem_responder.sv
// Directed bench for z8_extmem_responder: one zero-wait instance and one
// two-wait-state instance share the same bus stimulus.
module tb_z8_extmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        as_n, ds_n, rw;
  logic [7:0]  addr_hi, ad_in;
  logic [7:0]  adOut0, adOut2;
  logic        adOe0, adOe2, waitN0, waitN2;
  logic        rdStb0, rdStb2, wrStb0, wrStb2;
  logic [15:0] sel0, sel2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  z8_extmem_responder #(.BASE_ADDR(16'h1000), .ADDR_BITS(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .ds_n(ds_n), .rw(rw),
    .addr_hi(addr_hi), .ad_in(ad_in), .ad_out(adOut0), .ad_oe(adOe0),
    .wait_n(waitN0), .rd_strobe(rdStb0), .wr_strobe(wrStb0), .sel_addr(sel0)
  );

  z8_extmem_responder #(.BASE_ADDR(16'h1000), .ADDR_BITS(12), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .ds_n(ds_n), .rw(rw),
    .addr_hi(addr_hi), .ad_in(ad_in), .ad_out(adOut2), .ad_oe(adOe2),
    .wait_n(waitN2), .rd_strobe(rdStb2), .wr_strobe(wrStb2), .sel_addr(sel2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one bus step at the falling clock edge and wait one full clock
  task automatic applyStimulus(input logic asV, input logic dsV, input logic rwV,
                               input logic [7:0] hiV, input logic [7:0] adV);
    as_n    = asV;
    ds_n    = dsV;
    rw      = rwV;
    addr_hi = hiV;
    ad_in   = adV;
    @(negedge clk);
  endtask

  task automatic writeCycle(input logic [7:0] hiV, input logic [7:0] loV, input logic [7:0] dat);
    applyStimulus(1'b0, 1'b1, 1'b1, hiV, loV);
    applyStimulus(1'b1, 1'b1, 1'b1, hiV, loV);
    applyStimulus(1'b1, 1'b0, 1'b0, hiV, dat);
    checkOutput("wr_before_commit", 32'(wrStb0), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, hiV, dat);
    checkOutput("wr_pulse", 32'(wrStb0), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, hiV, dat);
    checkOutput("wr_pulse_end", 32'(wrStb0), 32'd0);
  endtask

  task automatic readCycle(input logic [7:0] hiV, input logic [7:0] loV, input logic [7:0] exp);
    applyStimulus(1'b0, 1'b1, 1'b1, hiV, loV);
    applyStimulus(1'b1, 1'b1, 1'b1, hiV, loV);
    applyStimulus(1'b1, 1'b0, 1'b1, hiV, loV);
    checkOutput("rd_latency_oe", 32'(adOe0), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, hiV, loV);
    checkOutput("rd_oe", 32'(adOe0), 32'd1);
    checkOutput("rd_data", 32'(adOut0), 32'(exp));
    checkOutput("rd_strobe", 32'(rdStb0), 32'd1);
    checkOutput("rd_wait_dut2", 32'(waitN2), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, hiV, loV);
    checkOutput("rd_release_oe", 32'(adOe0), 32'd0);
    checkOutput("rd_strobe_once", 32'(rdStb0), 32'd0);
    checkOutput("early_release_oe_dut2", 32'(adOe2), 32'd0);
    checkOutput("early_release_stb_dut2", 32'(rdStb2), 32'd0);
  endtask

  task automatic missCycle(input logic [7:0] hiV, input logic [7:0] loV);
    applyStimulus(1'b0, 1'b1, 1'b1, hiV, loV);
    applyStimulus(1'b1, 1'b1, 1'b1, hiV, loV);
    checkOutput("miss_sel", 32'(sel0), {16'h0, hiV, loV});
    applyStimulus(1'b1, 1'b0, 1'b1, hiV, loV);
    checkOutput("miss_wait_dut2", 32'(waitN2), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, hiV, loV);
    checkOutput("miss_oe", 32'(adOe0), 32'd0);
    checkOutput("miss_rdstb", 32'(rdStb0), 32'd0);
    checkOutput("miss_oe_dut2", 32'(adOe2), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, hiV, loV);
    checkOutput("miss_release_oe", 32'(adOe0), 32'd0);
    checkOutput("miss_wrstb", 32'(wrStb0), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; addr_hi = 8'h00; ad_in = 8'h00;
    #1;
    checkOutput("reset_oe", 32'(adOe0), 32'd0);
    checkOutput("reset_wait", 32'(waitN0), 32'd1);
    checkOutput("reset_sel", 32'(sel0), 32'h0);
    checkOutput("reset_out", 32'(adOut0), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] write then read 16'h1234");
    writeCycle(8'h12, 8'h34, 8'hA5);
    checkOutput("sel_latched", 32'(sel0), 32'h1234);
    readCycle(8'h12, 8'h34, 8'hA5);

    $display("[TB] misses below and above the window");
    missCycle(8'h08, 8'h00);
    missCycle(8'h20, 8'h00);
    missCycle(8'h0F, 8'hFF);

    $display("[TB] two wait states at 16'h1FFF");
    writeCycle(8'h1F, 8'hFF, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h1F, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h1F, 8'hFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h1F, 8'hFF);
    checkOutput("ws_wait_1", 32'(waitN2), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h1F, 8'hFF);
    checkOutput("ws_wait_2", 32'(waitN2), 32'd0);
    checkOutput("ws_no_oe_2", 32'(adOe2), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h1F, 8'hFF);
    checkOutput("ws_wait_done", 32'(waitN2), 32'd1);
    checkOutput("ws_no_oe_3", 32'(adOe2), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h1F, 8'hFF);
    checkOutput("ws_oe", 32'(adOe2), 32'd1);
    checkOutput("ws_data", 32'(adOut2), 32'h3C);
    checkOutput("ws_rdstb", 32'(rdStb2), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h1F, 8'hFF);
    checkOutput("ws_release_oe", 32'(adOe2), 32'd0);

    $display("[TB] abort a pending write at 16'h1010");
    writeCycle(8'h10, 8'h10, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h10, 8'h10);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 8'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 8'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h10, 8'h10);
    checkOutput("abort_wrstb", 32'(wrStb0), 32'd0);
    checkOutput("abort_oe", 32'(adOe0), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 8'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'h22);
    checkOutput("abort_no_commit", 32'(wrStb0), 32'd0);
    readCycle(8'h10, 8'h10, 8'h11);

    $display("[TB] window boundaries");
    writeCycle(8'h10, 8'h00, 8'h01);
    writeCycle(8'h1F, 8'hFF, 8'hFE);
    readCycle(8'h10, 8'h00, 8'h01);
    readCycle(8'h1F, 8'hFF, 8'hFE);
    missCycle(8'h0F, 8'hFF);

    $display("[TB] async reset during RD_DATA");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h10, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    checkOutput("pre_reset_oe", 32'(adOe0), 32'd1);
    checkOutput("pre_reset_wait_dut2", 32'(waitN2), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_oe", 32'(adOe0), 32'd0);
    checkOutput("async_reset_wait", 32'(waitN0), 32'd1);
    checkOutput("async_reset_sel", 32'(sel0), 32'h0);
    checkOutput("async_reset_wait_dut2", 32'(waitN2), 32'd1);
    as_n = 1'b1;
    ds_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    readCycle(8'h12, 8'h34, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
